// File: rtl/bc_sequencer.sv
// bc_sequencer: read-side controller for the VLSU broadcast ping-pong buffer.
// Holds up to two queued broadcast commands. Each command replays one buffer
// half to lane0 the requested number of times. The half is then invalidated
// and the command is reported done by ID.
module bc_sequencer #(
   parameter int  MaxBlen   = 32,
   parameter int  RepsWidth = 8,
   parameter int  IdWidth   = 3,
   localparam int BlenWidth = $clog2(MaxBlen + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [BlenWidth-1:0] cmd_blen_i,
   input  logic [RepsWidth-1:0] cmd_reps_i,
   input  logic [IdWidth-1:0]   cmd_id_i,
   input  logic                 abort_i,
   input  logic                 bc_valid_i,
   output logic                 bc_ready_o,
   output logic                 bc_invalidate_o,
   input  logic                 lane_ready_i,
   output logic                 lane_valid_o,
   output logic                 lane_last_elem_o,
   output logic                 lane_last_pass_o,
   output logic                 done_valid_o,
   output logic [IdWidth-1:0]   done_id_o,
   output logic                 done_abort_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, INVAL = 2'd2} state_t;

   // Two-entry command queue storage.
   logic [BlenWidth-1:0] q_blen [2];
   logic [RepsWidth-1:0] q_reps [2];
   logic [IdWidth-1:0]   q_id   [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           q_count;

   logic                 q_full;
   logic                 q_empty;
   logic                 push;
   logic                 take;
   logic                 store;
   logic                 pop;
   logic                 run;
   logic                 fire;

   // Next command to start: queue head, or the incoming command when the
   // queue is empty (so a command starts the cycle after its handshake).
   logic [BlenWidth-1:0] head_blen;
   logic [RepsWidth-1:0] head_reps;
   logic [IdWidth-1:0]   head_id;
   logic                 head_zero;

   state_t               state;
   logic [BlenWidth-1:0] act_blen;
   logic [RepsWidth-1:0] act_reps;
   logic [IdWidth-1:0]   act_id;
   logic [BlenWidth-1:0] elem_cnt;
   logic [RepsWidth-1:0] pass_cnt;
   logic                 last_elem;
   logic                 last_pass;

   assign q_full      = (q_count == 2'd2);
   assign q_empty     = (q_count == 2'd0);
   assign cmd_ready_o = !q_full;

   // A push coinciding with abort is dropped along with the rest of the queue.
   assign push = cmd_valid_i & !q_full & !abort_i;

   assign head_blen = q_empty ? cmd_blen_i : q_blen[rd_ptr];
   assign head_reps = q_empty ? cmd_reps_i : q_reps[rd_ptr];
   assign head_id   = q_empty ? cmd_id_i   : q_id[rd_ptr];
   assign head_zero = (head_blen == '0) | (head_reps == '0);

   // Commands start from IDLE or straight out of INVAL (no bubble).
   assign take  = (state != RUN) & !abort_i & (!q_empty | push);
   assign pop   = take & !q_empty;
   assign store = push & !(take & q_empty);

   assign run       = (state == RUN);
   assign last_elem = (elem_cnt == act_blen - BlenWidth'(1));
   assign last_pass = (pass_cnt == act_reps - RepsWidth'(1));

   // Abort suppresses the pop so the discarded element stays in the buffer.
   assign fire             = run & bc_valid_i & lane_ready_i & !abort_i;
   assign bc_ready_o       = fire;
   assign lane_valid_o     = run & bc_valid_i;
   assign lane_last_elem_o = run & last_elem;
   assign lane_last_pass_o = run & last_pass;

   // Queue entry writes; contents need no reset since occupancy is tracked.
   always_ff @(posedge clk_i) begin
      if (store) begin
         q_blen[wr_ptr] <= cmd_blen_i;
         q_reps[wr_ptr] <= cmd_reps_i;
         q_id[wr_ptr]   <= cmd_id_i;
      end
   end

   // Queue pointers and occupancy; abort empties the queue in any state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         q_count <= 2'd0;
      end else if (abort_i) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         q_count <= 2'd0;
      end else begin
         if (store) wr_ptr <= !wr_ptr;
         if (pop)   rd_ptr <= !rd_ptr;
         q_count <= q_count + 2'(store) - 2'(pop);
      end
   end

   // Sequencer FSM: load commands, count elements and passes, pulse invalidate/done.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state           <= IDLE;
         act_blen        <= '0;
         act_reps        <= '0;
         act_id          <= '0;
         elem_cnt        <= '0;
         pass_cnt        <= '0;
         bc_invalidate_o <= 1'b0;
         done_valid_o    <= 1'b0;
         done_id_o       <= '0;
         done_abort_o    <= 1'b0;
      end else begin
         bc_invalidate_o <= 1'b0;
         done_valid_o    <= 1'b0;
         done_id_o       <= '0;
         done_abort_o    <= 1'b0;
         case (state)
            IDLE, INVAL: begin
               if (take) begin
                  act_blen <= head_blen;
                  act_reps <= head_reps;
                  act_id   <= head_id;
                  elem_cnt <= '0;
                  pass_cnt <= '0;
                  if (head_zero) begin
                     // Nothing to stream: go straight to the invalidate cycle.
                     state           <= INVAL;
                     bc_invalidate_o <= 1'b1;
                     done_valid_o    <= 1'b1;
                     done_id_o       <= head_id;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (abort_i) begin
                  state           <= INVAL;
                  bc_invalidate_o <= 1'b1;
                  done_valid_o    <= 1'b1;
                  done_id_o       <= act_id;
                  done_abort_o    <= 1'b1;
               end else if (fire) begin
                  if (last_elem) begin
                     elem_cnt <= '0;
                     pass_cnt <= pass_cnt + RepsWidth'(1);
                     if (last_pass) begin
                        state           <= INVAL;
                        bc_invalidate_o <= 1'b1;
                        done_valid_o    <= 1'b1;
                        done_id_o       <= act_id;
                     end
                  end else begin
                     elem_cnt <= elem_cnt + BlenWidth'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
